owt_rx_ctrl: RTL and testbench

OWT_RX_CTRL -- requirements
Module: owt_rx_ctrl

---
 rtl/owt_pkg.sv | 27 ++
 rtl/owt_crc8.sv | 12 +
 rtl/owt_rx_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_owt_rx_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/owt_pkg.sv
// Shared types and constants for the one-wire-style frame receiver.
package owt_pkg;

    localparam int unsigned CMD_W     = 8;
    localparam int unsigned DAT_W     = 16;
    localparam int unsigned CRC_W     = 8;
    localparam int unsigned BIT_CNT_W = 5;

    localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_CMD  = 3'd2,
        S_DAT  = 3'd3,
        S_CRC  = 3'd4
    } owt_state_e;

    // One bit-serial step of the MSB-first CRC-8 (no reflection, no final XOR).
    function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                   input logic             b);
        logic fb;
        fb = crc[CRC_W-1] ^ b;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

endpackage

// File: rtl/owt_crc8.sv
// Combinational single-bit CRC-8 update used by the receiver datapath.
module owt_crc8
    import owt_pkg::*;
(
    input  logic [CRC_W-1:0] crc_in_i,
    input  logic             bit_i,
    output logic [CRC_W-1:0] crc_out_o
);

    assign crc_out_o = crc8_step(crc_in_i, bit_i);

endmodule

// File: rtl/owt_rx_ctrl.sv
// Frame receiver: preamble/start detection, cmd+data+CRC shift-in, CRC check,
// inter-symbol timeout and a one-deep valid/ready output holding register.
module owt_rx_ctrl
    import owt_pkg::*;
#(
    parameter int unsigned      PRE_N  = 4,
    parameter int unsigned      TO_W   = 12,
    parameter logic [TO_W-1:0]  TO_CYC = TO_W'(2000)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_sym_vld,
    input  logic              i_sym_data,
    output logic              o_frm_vld,
    input  logic              i_frm_rdy,
    output logic [CMD_W-1:0]  o_cmd,
    output logic [DAT_W-1:0]  o_data,
    output logic              o_crc_err,
    output logic              o_to_err,
    output logic              o_ovf_err,
    output logic              o_pre_err,
    output logic              o_busy
);

    localparam int unsigned PRE_W = (PRE_N < 2) ? 1 : $clog2(PRE_N + 1);

    // Output handshake: a frame is transferred on any cycle with
    // o_frm_vld & i_frm_rdy; o_cmd/o_data/o_crc_err are frozen while o_frm_vld is high.

    owt_state_e             state_q;
    logic [PRE_W-1:0]       pre_cnt_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [CMD_W-1:0]       cmd_sh_q;
    logic [DAT_W-1:0]       dat_sh_q;
    logic [CRC_W-2:0]       rx_crc_q;
    logic [CRC_W-1:0]       crc_q;
    logic [CRC_W-1:0]       crc_d;
    logic [TO_W-1:0]        to_q;

    logic                   frm_vld_q;
    logic [CMD_W-1:0]       cmd_q;
    logic [DAT_W-1:0]       data_q;
    logic                   crc_err_q;
    logic                   to_err_q;
    logic                   ovf_err_q;
    logic                   pre_err_q;

    logic                   to_hit;
    logic [CRC_W-1:0]       rx_crc_full;

    owt_crc8 u_crc8 (
        .crc_in_i  (crc_q),
        .bit_i     (i_sym_data),
        .crc_out_o (crc_d)
    );

    // A symbol arriving on the threshold cycle takes priority over the timeout.
    assign to_hit      = (state_q != S_IDLE) && !i_sym_vld && (to_q == TO_CYC - TO_W'(1));
    assign rx_crc_full = {rx_crc_q, i_sym_data};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            pre_cnt_q <= '0;
            bit_cnt_q <= '0;
            cmd_sh_q  <= '0;
            dat_sh_q  <= '0;
            rx_crc_q  <= '0;
            crc_q     <= '0;
            to_q      <= '0;
            frm_vld_q <= 1'b0;
            cmd_q     <= '0;
            data_q    <= '0;
            crc_err_q <= 1'b0;
            to_err_q  <= 1'b0;
            ovf_err_q <= 1'b0;
            pre_err_q <= 1'b0;
        end else begin
            to_err_q  <= 1'b0;
            ovf_err_q <= 1'b0;
            pre_err_q <= 1'b0;

            if (!i_en) begin
                state_q   <= S_IDLE;
                pre_cnt_q <= '0;
                bit_cnt_q <= '0;
                cmd_sh_q  <= '0;
                dat_sh_q  <= '0;
                rx_crc_q  <= '0;
                crc_q     <= '0;
                to_q      <= '0;
                frm_vld_q <= 1'b0;
                cmd_q     <= '0;
                data_q    <= '0;
                crc_err_q <= 1'b0;
            end else begin
                if (frm_vld_q && i_frm_rdy) begin
                    frm_vld_q <= 1'b0;
                end

                if (i_sym_vld) begin
                    to_q <= '0;
                end else if (state_q != S_IDLE && to_q != '1) begin
                    to_q <= to_q + TO_W'(1);
                end

                if (to_hit) begin
                    state_q   <= S_IDLE;
                    pre_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    crc_q     <= '0;
                    to_q      <= '0;
                    to_err_q  <= 1'b1;
                end else if (i_sym_vld) begin
                    unique case (state_q)
                        S_IDLE: begin
                            if (i_sym_data) begin
                                state_q   <= S_PRE;
                                pre_cnt_q <= PRE_W'(1);
                            end
                        end
                        S_PRE: begin
                            if (i_sym_data) begin
                                if (pre_cnt_q < PRE_W'(PRE_N)) begin
                                    pre_cnt_q <= pre_cnt_q + PRE_W'(1);
                                end
                            end else if (pre_cnt_q >= PRE_W'(PRE_N)) begin
                                state_q   <= S_CMD;
                                pre_cnt_q <= '0;
                                bit_cnt_q <= '0;
                                crc_q     <= '0;
                            end else begin
                                state_q   <= S_IDLE;
                                pre_cnt_q <= '0;
                                pre_err_q <= 1'b1;
                            end
                        end
                        S_CMD: begin
                            cmd_sh_q <= {cmd_sh_q[CMD_W-2:0], i_sym_data};
                            crc_q    <= crc_d;
                            if (bit_cnt_q == BIT_CNT_W'(CMD_W - 1)) begin
                                state_q   <= S_DAT;
                                bit_cnt_q <= '0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                            end
                        end
                        S_DAT: begin
                            dat_sh_q <= {dat_sh_q[DAT_W-2:0], i_sym_data};
                            crc_q    <= crc_d;
                            if (bit_cnt_q == BIT_CNT_W'(DAT_W - 1)) begin
                                state_q   <= S_CRC;
                                bit_cnt_q <= '0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                            end
                        end
                        S_CRC: begin
                            rx_crc_q <= rx_crc_full[CRC_W-2:0];
                            if (bit_cnt_q == BIT_CNT_W'(CRC_W - 1)) begin
                                state_q   <= S_IDLE;
                                bit_cnt_q <= '0;
                                crc_q     <= '0;
                                // Held frame not consumed this cycle: keep it, drop the new one.
                                if (frm_vld_q && !i_frm_rdy) begin
                                    ovf_err_q <= 1'b1;
                                end else begin
                                    frm_vld_q <= 1'b1;
                                    cmd_q     <= cmd_sh_q;
                                    data_q    <= dat_sh_q;
                                    crc_err_q <= (rx_crc_full != crc_q);
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                            end
                        end
                        default: begin
                            state_q <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign o_frm_vld = frm_vld_q;
    assign o_cmd     = cmd_q;
    assign o_data    = data_q;
    assign o_crc_err = crc_err_q;
    assign o_to_err  = to_err_q;
    assign o_ovf_err = ovf_err_q;
    assign o_pre_err = pre_err_q;
    assign o_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_owt_rx_ctrl.sv
// Directed bench for owt_rx_ctrl with a frame-level reference model.
module tb_owt_rx_ctrl;

    localparam int PRE_N  = 4;
    localparam int TO_CYC = 2000;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_en = 1'b0;
    logic        i_sym_vld = 1'b0;
    logic        i_sym_data = 1'b0;
    logic        i_frm_rdy = 1'b0;
    logic        o_frm_vld;
    logic [7:0]  o_cmd;
    logic [15:0] o_data;
    logic        o_crc_err;
    logic        o_to_err;
    logic        o_ovf_err;
    logic        o_pre_err;
    logic        o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    owt_rx_ctrl #(
        .PRE_N  (PRE_N),
        .TO_W   (12),
        .TO_CYC (12'd2000)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (i_en),
        .i_sym_vld  (i_sym_vld),
        .i_sym_data (i_sym_data),
        .o_frm_vld  (o_frm_vld),
        .i_frm_rdy  (i_frm_rdy),
        .o_cmd      (o_cmd),
        .o_data     (o_data),
        .o_crc_err  (o_crc_err),
        .o_to_err   (o_to_err),
        .o_ovf_err  (o_ovf_err),
        .o_pre_err  (o_pre_err),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // CRC-8 reference straight from the definition: poly 0x07, MSB first, init 0.
    function automatic logic [7:0] crc8_fn(input logic [23:0] w);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 23; i >= 0; i--) begin
            if (c[7] ^ w[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // Frame-level model: preamble length, collected frame bits, idle time.
    int         cyc = 0;
    int         last_sym_cyc = 0;
    int         m_ones = 0;
    bit         m_in_frame = 0;
    logic       m_bits[$];
    int         m_idle = 0;
    bit         m_busy;
    bit         m_done;
    logic [7:0]  f_cmd;
    logic [15:0] f_data;
    logic [7:0]  f_rx;
    logic        e_vld = 0;
    logic [7:0]  e_cmd = 0;
    logic [15:0] e_data = 0;
    logic        e_crc_err = 0;
    logic        e_to = 0;
    logic        e_ovf = 0;
    logic        e_pre = 0;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_ones = 0; m_in_frame = 0; m_bits.delete(); m_idle = 0;
            e_vld = 0; e_cmd = 0; e_data = 0; e_crc_err = 0;
            e_to = 0; e_ovf = 0; e_pre = 0;
        end else begin
            cyc++;
            e_to = 0; e_ovf = 0; e_pre = 0; m_done = 0;
            if (!i_en) begin
                m_ones = 0; m_in_frame = 0; m_bits.delete(); m_idle = 0;
                e_vld = 0; e_cmd = 0; e_data = 0; e_crc_err = 0;
            end else begin
                m_busy = (m_ones != 0) || m_in_frame;
                if (i_sym_vld) begin
                    m_idle = 0;
                    last_sym_cyc = cyc;
                    if (!m_busy) begin
                        if (i_sym_data) m_ones = 1;
                    end else if (!m_in_frame) begin
                        if (i_sym_data) begin
                            if (m_ones < PRE_N) m_ones++;
                        end else if (m_ones >= PRE_N) begin
                            m_ones = 0; m_in_frame = 1; m_bits.delete();
                        end else begin
                            m_ones = 0; e_pre = 1;
                        end
                    end else begin
                        m_bits.push_back(i_sym_data);
                        if (m_bits.size() == 32) begin
                            for (int i = 0; i < 8; i++)   f_cmd  = {f_cmd[6:0], m_bits[i]};
                            for (int i = 8; i < 24; i++)  f_data = {f_data[14:0], m_bits[i]};
                            for (int i = 24; i < 32; i++) f_rx   = {f_rx[6:0], m_bits[i]};
                            m_done = 1; m_in_frame = 0; m_bits.delete();
                        end
                    end
                end else if (m_busy) begin
                    m_idle++;
                    if (m_idle == TO_CYC) begin
                        m_ones = 0; m_in_frame = 0; m_bits.delete(); m_idle = 0; e_to = 1;
                    end
                end
                if (e_vld && i_frm_rdy) e_vld = 0;
                if (m_done) begin
                    if (e_vld) e_ovf = 1;
                    else begin
                        e_vld = 1; e_cmd = f_cmd; e_data = f_data;
                        e_crc_err = (f_rx != crc8_fn({f_cmd, f_data}));
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model; payload only matters while valid.
    always @(negedge i_clk) begin
        n_tests++;
        if (o_frm_vld !== e_vld || o_to_err !== e_to || o_ovf_err !== e_ovf ||
            o_pre_err !== e_pre || o_busy !== ((m_ones != 0) || m_in_frame) ||
            (e_vld && (o_cmd !== e_cmd || o_data !== e_data || o_crc_err !== e_crc_err))) begin
            n_fail++;
            $display("FAIL cycle_cmp cyc=%0d got vld=%b cmd=%h data=%h crc=%b to=%b ovf=%b pre=%b busy=%b exp vld=%b cmd=%h data=%h crc=%b to=%b ovf=%b pre=%b busy=%b",
                     cyc, o_frm_vld, o_cmd, o_data, o_crc_err, o_to_err, o_ovf_err, o_pre_err, o_busy,
                     e_vld, e_cmd, e_data, e_crc_err, e_to, e_ovf, e_pre, (m_ones != 0) || m_in_frame);
        end
    end

    // Observation counters for the directed checks.
    int          ob_vld_cyc = 0;
    int          ob_acc = 0;
    int          ob_to = 0;
    int          ob_ovf = 0;
    int          ob_pre = 0;
    int          ob_to_cyc = 0;
    logic [7:0]  ob_cmd = 0;
    logic [15:0] ob_data = 0;
    logic        ob_err = 0;

    always @(negedge i_clk) begin
        if (o_frm_vld) begin
            ob_vld_cyc++; ob_cmd <= o_cmd; ob_data <= o_data; ob_err <= o_crc_err;
            if (i_frm_rdy) ob_acc++;
        end
        if (o_to_err) begin ob_to++; ob_to_cyc = cyc; end
        if (o_ovf_err) ob_ovf++;
        if (o_pre_err) ob_pre++;
    end

    int b_vld, b_acc, b_to, b_ovf, b_pre;

    task automatic snap();
        b_vld = ob_vld_cyc; b_acc = ob_acc; b_to = ob_to; b_ovf = ob_ovf; b_pre = ob_pre;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Callers sit #1 after a rising edge; one symbol strobe then one idle cycle.
    task automatic sym(input logic d, input logic rdy_pulse);
        if (rdy_pulse) i_frm_rdy = 1'b1;
        i_sym_vld = 1'b1; i_sym_data = d;
        @(posedge i_clk); #1;
        i_sym_vld = 1'b0;
        if (rdy_pulse) i_frm_rdy = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic send_head(input int npre, input logic [7:0] c, input int ndat, input logic [15:0] d);
        for (int i = 0; i < npre; i++) sym(1'b1, 1'b0);
        sym(1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) sym(c[i], 1'b0);
        for (int i = 15; i > 15 - ndat; i--) sym(d[i], 1'b0);
    endtask

    task automatic send_frame(input int npre, input logic [7:0] c, input logic [15:0] d,
                              input logic [7:0] crc, input logic rdy_last);
        send_head(npre, c, 16, d);
        for (int i = 7; i > 0; i--) sym(crc[i], 1'b0);
        sym(crc[0], rdy_last);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_vld", {31'd0, o_frm_vld}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_fields", {o_cmd, o_data, 5'd0, o_crc_err, o_to_err, o_ovf_err}, 32'd0);
        i_rst_n = 1'b1; i_en = 1'b1;
        idle(2);
        check("crc_ref_a51234", {24'd0, crc8_fn(24'hA51234)}, 32'h79);

        // Normal frame, consumer always ready
        i_frm_rdy = 1'b1; snap();
        send_frame(4, 8'hA5, 16'h1234, 8'h79, 1'b0);
        idle(3);
        check("norm_vld_cycles", ob_vld_cyc - b_vld, 1);
        check("norm_cmd", {24'd0, ob_cmd}, 32'hA5);
        check("norm_data", {16'd0, ob_data}, 32'h1234);
        check("norm_crc_err", {31'd0, ob_err}, 0);

        // CRC LSB flipped
        snap();
        send_frame(4, 8'hA5, 16'h1234, 8'h78, 1'b0);
        idle(3);
        check("crcf_vld_cycles", ob_vld_cyc - b_vld, 1);
        check("crcf_crc_err", {31'd0, ob_err}, 1);
        check("crcf_fields", {ob_cmd, 8'd0, ob_data}, 32'hA5001234);

        // Short preamble, then a frame with a long (saturating) preamble
        snap();
        sym(1'b1, 1'b0); sym(1'b1, 1'b0); sym(1'b1, 1'b0); sym(1'b0, 1'b0);
        check("short_pre_err", ob_pre - b_pre, 1);
        check("short_pre_busy", {31'd0, o_busy}, 0);
        send_frame(6, 8'h3C, 16'hBEEF, crc8_fn(24'h3CBEEF), 1'b0);
        idle(3);
        check("after_pre_cmd", {24'd0, ob_cmd}, 32'h3C);
        check("after_pre_data", {16'd0, ob_data}, 32'hBEEF);
        check("after_pre_err", {31'd0, ob_err}, 0);

        // Timeout after 10 data bits
        snap();
        send_head(4, 8'hC3, 10, 16'h5A5A);
        check("to_busy_before", {31'd0, o_busy}, 1);
        idle(TO_CYC + 5);
        check("to_pulses", ob_to - b_to, 1);
        check("to_latency", ob_to_cyc - last_sym_cyc, TO_CYC);
        check("to_busy_after", {31'd0, o_busy}, 0);
        check("to_no_frame", ob_vld_cyc - b_vld, 0);

        // Backpressure: second frame overflows, first one held
        i_frm_rdy = 1'b0; snap();
        send_frame(4, 8'h11, 16'h0001, crc8_fn(24'h110001), 1'b0);
        send_frame(4, 8'h22, 16'h0002, crc8_fn(24'h220002), 1'b0);
        check("bp_ovf", ob_ovf - b_ovf, 1);
        check("bp_hold_cmd", {24'd0, o_cmd}, 32'h11);
        check("bp_hold_vld", {31'd0, o_frm_vld}, 1);
        i_frm_rdy = 1'b1;
        @(posedge i_clk); #1;
        check("bp_release_vld", {31'd0, o_frm_vld}, 0);

        // Completion on the same cycle the held frame is accepted
        i_frm_rdy = 1'b0;
        send_frame(4, 8'h44, 16'h4444, crc8_fn(24'h444444), 1'b0);
        snap();
        send_frame(4, 8'h55, 16'h5555, crc8_fn(24'h555555), 1'b1);
        check("same_cyc_vld", {31'd0, o_frm_vld}, 1);
        check("same_cyc_cmd", {24'd0, o_cmd}, 32'h55);
        check("same_cyc_no_ovf", ob_ovf - b_ovf, 0);

        // Disable mid-DAT while a frame is still held
        send_head(4, 8'h99, 5, 16'hFFFF);
        i_en = 1'b0;
        @(posedge i_clk); #1;
        check("dis_busy", {31'd0, o_busy}, 0);
        check("dis_vld", {31'd0, o_frm_vld}, 0);
        check("dis_fields", {o_cmd, o_data, 7'd0, o_crc_err}, 0);
        sym(1'b1, 1'b0);
        check("dis_ignore_sym", {31'd0, o_busy}, 0);
        i_en = 1'b1; i_frm_rdy = 1'b1; snap();
        send_frame(4, 8'h66, 16'h0F0F, crc8_fn(24'h660F0F), 1'b0);
        idle(3);
        check("dis_next_cmd", {24'd0, ob_cmd}, 32'h66);
        check("dis_next_acc", ob_acc - b_acc, 1);

        // Asynchronous reset mid-DAT
        send_head(4, 8'h77, 6, 16'hFFFF);
        i_rst_n = 1'b0;
        #2;
        check("arst_busy", {31'd0, o_busy}, 0);
        check("arst_fields", {o_cmd, o_data, 4'd0, o_frm_vld, o_crc_err, o_to_err, o_ovf_err}, 0);
        idle(2);
        i_rst_n = 1'b1; snap();
        idle(2);
        send_frame(4, 8'h77, 16'hA0A0, crc8_fn(24'h77A0A0), 1'b0);
        idle(3);
        check("arst_next_cmd", {24'd0, ob_cmd}, 32'h77);
        check("arst_next_data", {16'd0, ob_data}, 32'hA0A0);
        check("arst_next_err", {31'd0, ob_err}, 0);
        check("arst_no_err_pulse", (ob_to - b_to) + (ob_pre - b_pre) + (ob_ovf - b_ovf), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
